// File: rtl/intra_chroma8x8_sad.sv
// intra_chroma8x8_sad
// Builds the vertical, horizontal and DC chroma intra predictions for one
// 8x8 block from its latched top/left neighbours. The source block arrives
// one row per accepted cycle. Each row updates the per-mode SAD accumulators
// and writes that row of the three residue arrays. A one-cycle `done` pulse
// marks the point where all results are final.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start               : begin a block (sampled only when idle)
//   mbnumber            : block index, latched at start
//   top[8], left[8]     : neighbour samples, latched at start
//   top_avail/left_avail: neighbour availability, latched at start
//   row_valid, cur_row  : next source row (index 0 = leftmost)
//   busy                : high whenever the block is not idle
//   done                : one-cycle pulse, results valid
//   sads[3]             : SAD/64 for {vertical, horizontal, DC}
//   vres/hres/dcres[64] : residues, index = row*8+col
//   mbnumber_out        : latched block index
module intra_chroma8x8_sad (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [12:0] mbnumber,
    input  logic [7:0]  top [7:0],
    input  logic [7:0]  left [7:0],
    input  logic        top_avail,
    input  logic        left_avail,
    input  logic        row_valid,
    input  logic [7:0]  cur_row [7:0],
    output logic        busy,
    output logic        done,
    output logic [7:0]  sads [2:0],
    output logic [7:0]  vres [63:0],
    output logic [7:0]  hres [63:0],
    output logic [7:0]  dcres [63:0],
    output logic [12:0] mbnumber_out
);

    typedef enum logic [1:0] {IDLE, DCCALC, ACCUM, DONE} state_t;

    state_t      state;
    logic [7:0]  top_q [7:0];
    logic [7:0]  left_q [7:0];
    logic        top_av_q;
    logic        left_av_q;
    logic [7:0]  dc_q [3:0];      // quadrant index = {row half, col half}
    logic [2:0]  row_cnt;
    logic [13:0] acc_v, acc_h, acc_dc;

    // Absolute difference evaluated at 9-bit precision so 0-255 does not wrap.
    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[8] ? (~d + 9'd1) : d;
    endfunction

    // ------------------------------------------------------------------
    // Quadrant DC values from the latched neighbours.
    // ------------------------------------------------------------------
    logic [9:0]  st_sum [3:0];
    logic [9:0]  sl_sum [3:0];
    logic [7:0]  dc_new [3:0];
    logic [10:0] both_sum, top_rnd, left_rnd;

    // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
    always_comb begin
        both_sum = '0;
        top_rnd  = '0;
        left_rnd = '0;
        for (int q = 0; q < 4; q++) begin
            st_sum[q] = '0;
            sl_sum[q] = '0;
            for (int k = 0; k < 4; k++) begin
                st_sum[q] = st_sum[q] + {2'b00, top_q[(q % 2) * 4 + k]};
                sl_sum[q] = sl_sum[q] + {2'b00, left_q[(q / 2) * 4 + k]};
            end
            both_sum = {1'b0, st_sum[q]} + {1'b0, sl_sum[q]} + 11'd4;
            top_rnd  = {1'b0, st_sum[q]} + 11'd2;
            left_rnd = {1'b0, sl_sum[q]} + 11'd2;
            dc_new[q] = 8'd128;
            if (q == 0 || q == 3) begin
                // Diagonal quadrants average whatever is available.
                if (top_av_q && left_av_q) dc_new[q] = both_sum[10:3];
                else if (top_av_q)         dc_new[q] = top_rnd[9:2];
                else if (left_av_q)        dc_new[q] = left_rnd[9:2];
            end else if (q == 1) begin
                // Top-right quadrant prefers its top neighbours.
                if (top_av_q)       dc_new[q] = top_rnd[9:2];
                else if (left_av_q) dc_new[q] = left_rnd[9:2];
            end else begin
                // Bottom-left quadrant prefers its left neighbours.
                if (left_av_q)     dc_new[q] = left_rnd[9:2];
                else if (top_av_q) dc_new[q] = top_rnd[9:2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-row residues and absolute-difference sums for the current row.
    // ------------------------------------------------------------------
    logic [7:0]  pred_dc [7:0];
    logic [7:0]  res_v [7:0];
    logic [7:0]  res_h [7:0];
    logic [7:0]  res_dc [7:0];
    logic [10:0] row_v, row_h, row_dc;
    logic [13:0] acc_v_nxt, acc_h_nxt, acc_dc_nxt;

    always_comb begin
        row_v = '0;
        row_h = '0;
        row_dc = '0;
        for (int c = 0; c < 8; c++) begin
            pred_dc[c] = dc_q[{row_cnt[2], c >= 4}];
            res_v[c]   = cur_row[c] - top_q[c];
            res_h[c]   = cur_row[c] - left_q[row_cnt];
            res_dc[c]  = cur_row[c] - pred_dc[c];
            row_v  = row_v  + {2'b00, abs_diff(cur_row[c], top_q[c])};
            row_h  = row_h  + {2'b00, abs_diff(cur_row[c], left_q[row_cnt])};
            row_dc = row_dc + {2'b00, abs_diff(cur_row[c], pred_dc[c])};
        end
        acc_v_nxt  = acc_v  + {3'b000, row_v};
        acc_h_nxt  = acc_h  + {3'b000, row_h};
        acc_dc_nxt = acc_dc + {3'b000, row_dc};
    end

    // ------------------------------------------------------------------
    // Control FSM and result registers.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            row_cnt      <= '0;
            acc_v        <= '0;
            acc_h        <= '0;
            acc_dc       <= '0;
            top_av_q     <= 1'b0;
            left_av_q    <= 1'b0;
            mbnumber_out <= '0;
            for (int i = 0; i < 3; i++) sads[i] <= '0;
            for (int i = 0; i < 4; i++) dc_q[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                top_q[i]  <= '0;
                left_q[i] <= '0;
            end
            // NOTE: the residue arrays are output flops that must read zero after reset, so they are reset like any other register.
            for (int i = 0; i < 64; i++) begin
                vres[i]  <= '0;
                hres[i]  <= '0;
                dcres[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        top_av_q     <= top_avail;
                        left_av_q    <= left_avail;
                        mbnumber_out <= mbnumber;
                        for (int i = 0; i < 8; i++) begin
                            top_q[i]  <= top[i];
                            left_q[i] <= left[i];
                        end
                        busy  <= 1'b1;
                        state <= DCCALC;
                    end
                end
                DCCALC: begin
                    for (int i = 0; i < 4; i++) dc_q[i] <= dc_new[i];
                    for (int i = 0; i < 3; i++) sads[i] <= '0;
                    for (int i = 0; i < 64; i++) begin
                        vres[i]  <= '0;
                        hres[i]  <= '0;
                        dcres[i] <= '0;
                    end
                    acc_v   <= '0;
                    acc_h   <= '0;
                    acc_dc  <= '0;
                    row_cnt <= '0;
                    state   <= ACCUM;
                end
                ACCUM: begin
                    if (row_valid) begin
                        for (int c = 0; c < 8; c++) begin
                            vres[{row_cnt, 3'(c)}]  <= res_v[c];
                            hres[{row_cnt, 3'(c)}]  <= res_h[c];
                            dcres[{row_cnt, 3'(c)}] <= res_dc[c];
                        end
                        acc_v   <= acc_v_nxt;
                        acc_h   <= acc_h_nxt;
                        acc_dc  <= acc_dc_nxt;
                        // Unavailable directions report the worst possible cost.
                        sads[0] <= top_av_q  ? 8'(acc_v_nxt >> 6) : 8'hFF;
                        sads[1] <= left_av_q ? 8'(acc_h_nxt >> 6) : 8'hFF;
                        sads[2] <= 8'(acc_dc_nxt >> 6);
                        row_cnt <= row_cnt + 3'd1;
                        if (row_cnt == 3'd7) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/intra_chroma8x8_sad.md
# intra_chroma8x8_sad

Upstream stage of the chroma 8x8 mode saver. Builds the three H.264 chroma intra predictions (vertical, horizontal, DC) for one 8x8 chroma block from its top/left neighbours. Streams in the source block one row per accepted cycle, accumulating per-mode SADs and residues. On completion it pulses `done`, which drives the saver's `enable`, with `sads`, `vres`, `hres`, `dcres` and `mbnumber_out` stable.

## Interface
- No parameters; block size fixed at 8x8, 8-bit samples.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a block; sampled only in IDLE.
- `mbnumber` input 13: block index; latched at start.
- `top` input 8x[7:0] (`[7:0] top [7:0]`): top neighbour row, index 0 = leftmost; latched at start.
- `left` input 8x[7:0]: left neighbour column, index 0 = topmost; latched at start.
- `top_avail`, `left_avail` input 1 each: neighbour availability; latched at start.
- `row_valid` input 1: `cur_row` holds the next source row.
- `cur_row` input 8x[7:0]: source row, index 0 = leftmost.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse; results valid.
- `sads` output 3x[7:0]: index 0 = vertical, 1 = horizontal, 2 = DC.
- `vres`, `hres`, `dcres` output 64x[7:0]: residues, index = row*8+col.
- `mbnumber_out` output 13: latched `mbnumber`.

## Operation
- FSM states: IDLE, DCCALC, ACCUM, DONE.
  - IDLE: on `start`, latch `top`, `left`, `top_avail`, `left_avail` and `mbnumber`; go to DCCALC.
  - DCCALC: compute four quadrant DC values; clear accumulators and row counter; go to ACCUM.
  - ACCUM: each cycle with `row_valid`=1 accepts row r (r = 0..7). After r=7 is accepted, go to DONE.
  - DONE: `done`=1 for exactly one cycle; go to IDLE.
- Predictions: V(r,c)=top[c]; H(r,c)=left[r]; DC(r,c)=dc[quadrant(r>>2, c>>2)].
- DC per quadrant. St = sum of the 4 top samples over the quadrant's columns; Sl = sum of the 4 left samples over its rows.
  - Quadrants (0,0) and (1,1): both available gives (St+Sl+4)>>3. Top only gives (St+2)>>2. Left only gives (Sl+2)>>2. Neither gives 128.
  - Quadrant (0,1): top available gives (St+2)>>2; else left available gives (Sl+2)>>2; else 128.
  - Quadrant (1,0): left available gives (Sl+2)>>2; else top available gives (St+2)>>2; else 128.
- Residue = (cur - pred) mod 256, 8-bit two's-complement wrap, written into row r of the matching residue array.
- SAD accumulators are 14-bit, unsigned, and accumulate |cur - pred| computed at 9-bit precision. Maximum is 64*255 = 16320, so they never overflow.
- Output SAD = acc>>6, giving 0..255 without saturation.
- Unavailable-mode override: `sads[0]`=255 if !top_avail and `sads[1]`=255 if !left_avail. Residues for those modes still use the latched neighbour values.
- Outputs stay stable from DONE until the next DCCALC clears them. Residues and SADs are registered; they update in the cycle after the accepting edge.

## Timing
- Reset values: `busy`=0, `done`=0, all `sads`/residues = 0, `mbnumber_out`=0, state IDLE, row counter 0.
- Latency: the edge that samples `start` enters DCCALC. ACCUM is entered one edge later. With `row_valid` held high, rows are accepted on the next 8 edges. `done` goes high after the 10th edge counted from the start edge.
- Each `row_valid`=0 cycle in ACCUM adds exactly one cycle of latency. Nothing is accepted and accumulators hold.
- `row_valid` outside ACCUM is ignored. `start` while `busy`=1 is ignored, not queued.
- `start` asserted in the DONE cycle is ignored. Back-to-back throughput is therefore 11 cycles per block.
- `reset` in any state returns to IDLE next edge with all outputs at reset values. A partial block is discarded and no `done` is issued.

## Test plan
- Flat block: top=left=cur=100 everywhere, both available -> all residues 0, `sads`={0,0,0}, `done` after 10 cycles, `mbnumber_out`=mbnumber.
- Vertical match: top[c]=10*(c+1), left=0, both available, each cur row = top -> `vres` all 0, `sads[0]`=0. `hres[c]`=10*(c+1). DC quadrant (0,0)=(100+0+4)>>3=13.
- No neighbours: both avail=0, cur all 128 -> DC=128 in all quadrants, `dcres` all 0, `sads`={255,255,0}.
- Top only: top all 200, left_avail=0, cur all 0 -> all DC quadrants 200, `dcres`=0x38 (wrap of -200), `sads[2]`=(64*200)>>6=200, `sads[1]`=255.
- Stalls: deassert `row_valid` for 3 cycles mid-block -> `done` at cycle 13 with results identical to the unstalled run. `start` pulses while busy produce no extra `done`.
- Reset at row 4: assert `reset` one cycle -> `busy`=0 and all outputs 0 next cycle, no `done`. A fresh `start` then completes normally.
